// File: rtl/hazard_unit.sv
// Hazard and forwarding unit for the 5-stage MIPS pipeline: operand forwarding selects,
// load-use / branch-compare / divide stalls, and a saturating stall-cycle counter.
module hazard_unit #(
   parameter int unsigned DIV_CYCLES = 32,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rsD,
   input  logic [4:0]       rtD,
   input  logic [4:0]       rsE,
   input  logic [4:0]       rtE,
   input  logic [4:0]       writeregE,
   input  logic             regwriteE,
   input  logic [4:0]       writeregM,
   input  logic             regwriteM,
   input  logic             memtoregM,
   input  logic [4:0]       writeregW,
   input  logic             regwriteW,
   input  logic             memtoregE,
   input  logic             branchD,
   input  logic             jrD,
   input  logic             divstartE,
   output logic             forwardaD,
   output logic             forwardbD,
   output logic [1:0]       forwardaE,
   output logic [1:0]       forwardbE,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             flushE,
   output logic             div_busy,
   output logic             div_done,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int unsigned DCW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES - 1) : 1;
   localparam logic [DCW-1:0] DIV_LOAD = DCW'(DIV_CYCLES - 2);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [DCW-1:0]   div_cnt_q, div_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic lwstall, brstall, divstall;
   logic e_hits_rs, e_hits_rt, m_hits_rs, m_hits_rt;

   always_comb begin
      forwardaE = 2'b00;
      if ((|rsE) && regwriteM && (rsE == writeregM))      forwardaE = 2'b10;
      else if ((|rsE) && regwriteW && (rsE == writeregW)) forwardaE = 2'b01;

      forwardbE = 2'b00;
      if ((|rtE) && regwriteM && (rtE == writeregM))      forwardbE = 2'b10;
      else if ((|rtE) && regwriteW && (rtE == writeregW)) forwardbE = 2'b01;

      forwardaD = (|rsD) && regwriteM && (rsD == writeregM);
      forwardbD = (|rtD) && regwriteM && (rtD == writeregM);
   end

   always_comb begin
      lwstall   = memtoregE && (|writeregE) && ((writeregE == rsD) || (writeregE == rtD));
      e_hits_rs = regwriteE && (|writeregE) && (writeregE == rsD);
      e_hits_rt = regwriteE && (|writeregE) && (writeregE == rtD);
      m_hits_rs = memtoregM && (|writeregM) && (writeregM == rsD);
      m_hits_rt = memtoregM && (|writeregM) && (writeregM == rtD);
      // jr reads rs only, so an rt match must not hold it back
      brstall   = (branchD && (e_hits_rs || e_hits_rt || m_hits_rs || m_hits_rt)) ||
                  (jrD && (e_hits_rs || m_hits_rs));
      divstall  = ((state_q == S_IDLE) && divstartE) || (state_q == S_BUSY);

      stallF    = lwstall || brstall || divstall;
      stallD    = stallF;
      stallE    = divstall;
      flushE    = (lwstall || brstall) && !divstall;
      div_busy  = (state_q == S_BUSY);
      div_done  = (state_q == S_DONE);
      stall_cnt = stall_cnt_q;
   end

   always_comb begin
      state_d   = state_q;
      div_cnt_d = div_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (divstartE) begin
               state_d   = S_BUSY;
               div_cnt_d = DIV_LOAD;
            end
         end
         S_BUSY: begin
            if (div_cnt_q == '0) state_d = S_DONE;
            else                 div_cnt_d = div_cnt_q - DCW'(1);
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      stall_cnt_d = stall_cnt_q;
      if (stallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         div_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit (DIV_CYCLES=4, CNT_W=4): expected outputs are queued
// when stimulus is applied and compared once the DUT outputs have settled.
module tb_hazard_unit;

   logic       clk, rst;
   logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
   logic       regwriteE, regwriteM, memtoregM, regwriteW, memtoregE;
   logic       branchD, jrD, divstartE;
   logic       forwardaD, forwardbD, stallF, stallD, stallE, flushE, div_busy, div_done;
   logic [1:0] forwardaE, forwardbE;
   logic [3:0] stall_cnt;

   typedef struct packed {
      logic [11:0] o;
      logic [3:0]  cnt;
   } exp_t;

   exp_t       sb[$];
   exp_t       got, e;
   int         checks = 0;
   int         errors = 0;
   logic [3:0] exp_cnt = '0;

   hazard_unit #(.DIV_CYCLES(4), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
      .writeregE(writeregE), .regwriteE(regwriteE),
      .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
      .writeregW(writeregW), .regwriteW(regwriteW),
      .memtoregE(memtoregE), .branchD(branchD), .jrD(jrD), .divstartE(divstartE),
      .forwardaD(forwardaD), .forwardbD(forwardbD),
      .forwardaE(forwardaE), .forwardbE(forwardbE),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .flushE(flushE),
      .div_busy(div_busy), .div_done(div_done), .stall_cnt(stall_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   function automatic logic [11:0] mk(logic fad, logic fbd, logic [1:0] fae, logic [1:0] fbe,
                                      logic sf, logic sd, logic se, logic fe, logic bz, logic dn);
      return {fad, fbd, fae, fbe, sf, sd, se, fe, bz, dn};
   endfunction

   function automatic logic [11:0] cur_out();
      return {forwardaD, forwardbD, forwardaE, forwardbE, stallF, stallD, stallE, flushE,
              div_busy, div_done};
   endfunction

   // Advance one clock; the stall counter model counts a cycle the bench expected to stall.
   task automatic tick(input logic stalled);
      @(posedge clk);
      if (stalled && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
      #1;
   endtask

   task automatic clear_inputs();
      rsD = '0; rtD = '0; rsE = '0; rtE = '0;
      writeregE = '0; writeregM = '0; writeregW = '0;
      regwriteE = 1'b0; regwriteM = 1'b0; memtoregM = 1'b0; regwriteW = 1'b0;
      memtoregE = 1'b0; branchD = 1'b0; jrD = 1'b0; divstartE = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b0;
      exp_cnt = '0;
      #1;
      rst = 1'b1;
      tick(1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      clear_inputs();
      sb.push_back({mk(0,0,2'b00,2'b00,0,0,0,0,0,0), 4'd0});
      #2;
      got = {cur_out(), stall_cnt}; e = sb.pop_front(); checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL reset_idle: got o=%b cnt=%0d expected o=%b cnt=%0d", got.o, got.cnt, e.o, e.cnt);
      end
      regwriteM = 1'b1; writeregM = 5'd5; rsE = 5'd5;
      sb.push_back({mk(0,0,2'b10,2'b00,0,0,0,0,0,0), 4'd0});
      #1;
      got = {cur_out(), stall_cnt}; e = sb.pop_front(); checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL reset_comb: got o=%b cnt=%0d expected o=%b cnt=%0d", got.o, got.cnt, e.o, e.cnt);
      end
      clear_inputs();
      rst = 1'b1;
      tick(1'b0);
   endtask

   task automatic test_forward_e();
      // rwM wM rwW wW rsE rtE | expected forwardaE forwardbE
      logic [4:0] t_wm[6]  = '{5, 0, 5, 7, 7, 9};
      logic [4:0] t_ww[6]  = '{5, 0, 5, 5, 5, 9};
      logic       t_rwm[6] = '{1, 1, 0, 1, 1, 1};
      logic       t_rww[6] = '{1, 1, 1, 1, 0, 1};
      logic [4:0] t_rs[6]  = '{5, 0, 5, 5, 5, 9};
      logic [4:0] t_rt[6]  = '{0, 0, 5, 7, 7, 9};
      logic [1:0] t_fa[6]  = '{2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
      logic [1:0] t_fb[6]  = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b10};
      for (int i = 0; i < 6; i++) begin
         clear_inputs();
         regwriteM = t_rwm[i]; writeregM = t_wm[i];
         regwriteW = t_rww[i]; writeregW = t_ww[i];
         rsE = t_rs[i]; rtE = t_rt[i];
         sb.push_back({mk(0,0,t_fa[i],t_fb[i],0,0,0,0,0,0), exp_cnt});
         #2;
         got = {cur_out(), stall_cnt}; e = sb.pop_front(); checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL fwd_e[%0d]: got o=%b cnt=%0d expected o=%b cnt=%0d", i, got.o, got.cnt, e.o, e.cnt);
         end
         tick(1'b0);
      end
   endtask

   task automatic test_random_forward();
      logic [1:0] fa, fb;
      logic       fad, fbd;
      for (int i = 0; i < 24; i++) begin
         clear_inputs();
         rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
         rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
         writeregM = 5'($urandom_range(0, 3)); writeregW = 5'($urandom_range(0, 3));
         regwriteM = 1'($urandom_range(0, 1)); regwriteW = 1'($urandom_range(0, 1));
         fa  = (rsE != 0 && regwriteM && rsE == writeregM) ? 2'b10 :
               (rsE != 0 && regwriteW && rsE == writeregW) ? 2'b01 : 2'b00;
         fb  = (rtE != 0 && regwriteM && rtE == writeregM) ? 2'b10 :
               (rtE != 0 && regwriteW && rtE == writeregW) ? 2'b01 : 2'b00;
         fad = (rsD != 0) && regwriteM && (rsD == writeregM);
         fbd = (rtD != 0) && regwriteM && (rtD == writeregM);
         sb.push_back({mk(fad,fbd,fa,fb,0,0,0,0,0,0), exp_cnt});
         #2;
         got = {cur_out(), stall_cnt}; e = sb.pop_front(); checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL fwd_rand[%0d]: got o=%b cnt=%0d expected o=%b cnt=%0d", i, got.o, got.cnt, e.o, e.cnt);
         end
         tick(1'b0);
      end
   endtask

   task automatic test_lwstall();
      // memtoregE writeregE rsD rtD | expected stall
      logic       t_mem[5] = '{1, 1, 1, 0, 1};
      logic [4:0] t_we[5]  = '{8, 0, 8, 8, 8};
      logic [4:0] t_rs[5]  = '{8, 0, 1, 8, 1};
      logic [4:0] t_rt[5]  = '{0, 0, 8, 8, 2};
      logic       t_st[5]  = '{1, 0, 1, 0, 0};
      for (int i = 0; i < 5; i++) begin
         clear_inputs();
         memtoregE = t_mem[i]; writeregE = t_we[i]; rsD = t_rs[i]; rtD = t_rt[i];
         sb.push_back({mk(0,0,2'b00,2'b00,t_st[i],t_st[i],0,t_st[i],0,0), exp_cnt});
         #2;
         got = {cur_out(), stall_cnt}; e = sb.pop_front(); checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL lwstall[%0d]: got o=%b cnt=%0d expected o=%b cnt=%0d", i, got.o, got.cnt, e.o, e.cnt);
         end
         tick(t_st[i]);
      end
   endtask

   task automatic test_branch();
      // br jr rwE wE memM rwM wM rsD rtD | expected fbd stall
      logic       t_br[7]  = '{1, 1, 1, 0, 0, 1, 0};
      logic       t_jr[7]  = '{0, 0, 0, 1, 1, 0, 0};
      logic       t_rwe[7] = '{1, 0, 0, 1, 1, 1, 1};
      logic [4:0] t_we[7]  = '{3, 0, 0, 3, 3, 0, 3};
      logic       t_mm[7]  = '{0, 0, 1, 0, 0, 0, 0};
      logic       t_rwm[7] = '{0, 1, 1, 0, 0, 0, 0};
      logic [4:0] t_wm[7]  = '{0, 3, 3, 0, 0, 0, 0};
      logic [4:0] t_rs[7]  = '{1, 1, 1, 1, 3, 0, 3};
      logic [4:0] t_rt[7]  = '{3, 3, 3, 3, 0, 0, 0};
      logic       t_fbd[7] = '{0, 1, 1, 0, 0, 0, 0};
      logic       t_st[7]  = '{1, 0, 1, 0, 1, 0, 0};
      for (int i = 0; i < 7; i++) begin
         clear_inputs();
         branchD = t_br[i]; jrD = t_jr[i]; regwriteE = t_rwe[i]; writeregE = t_we[i];
         memtoregM = t_mm[i]; regwriteM = t_rwm[i]; writeregM = t_wm[i];
         rsD = t_rs[i]; rtD = t_rt[i];
         sb.push_back({mk(0,t_fbd[i],2'b00,2'b00,t_st[i],t_st[i],0,t_st[i],0,0), exp_cnt});
         #2;
         got = {cur_out(), stall_cnt}; e = sb.pop_front(); checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL branch[%0d]: got o=%b cnt=%0d expected o=%b cnt=%0d", i, got.o, got.cnt, e.o, e.cnt);
         end
         tick(t_st[i]);
      end
   endtask

   // Holds divstartE for n cycles starting from IDLE; pattern per DIV_CYCLES=4 is
   // stall on cycles 0-3, busy on 1-3, done on 4, then a fresh div may start on 5.
   task automatic test_div_seq(input int n, input string name);
      logic st, bz, dn;
      do_reset();
      for (int i = 0; i <= n; i++) begin
         divstartE = (i < n);
         st = ((i % 5) != 4) && (i < n);
         bz = ((i % 5) >= 1) && ((i % 5) <= 3);
         dn = ((i % 5) == 4);
         sb.push_back({mk(0,0,2'b00,2'b00,st,st,st,0,bz,dn), exp_cnt});
         #2;
         got = {cur_out(), stall_cnt}; e = sb.pop_front(); checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL %s[%0d]: got o=%b cnt=%0d expected o=%b cnt=%0d", name, i, got.o, got.cnt, e.o, e.cnt);
         end
         tick(st);
      end
      divstartE = 1'b0;
   endtask

   task automatic test_div_lw_reset();
      logic [11:0] t_o[3];
      t_o[0] = mk(0,0,2'b00,2'b00,1,1,1,0,0,0);
      t_o[1] = mk(0,0,2'b00,2'b00,1,1,1,0,1,0);
      t_o[2] = mk(0,0,2'b00,2'b00,1,1,1,0,1,0);
      do_reset();
      memtoregE = 1'b1; writeregE = 5'd8; rsD = 5'd8;
      for (int i = 0; i < 3; i++) begin
         divstartE = (i == 0);
         sb.push_back({t_o[i], exp_cnt});
         #2;
         got = {cur_out(), stall_cnt}; e = sb.pop_front(); checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL div_lw[%0d]: got o=%b cnt=%0d expected o=%b cnt=%0d", i, got.o, got.cnt, e.o, e.cnt);
         end
         if (i < 2) tick(1'b1);
      end
      rst = 1'b0;
      exp_cnt = '0;
      sb.push_back({mk(0,0,2'b00,2'b00,1,1,0,1,0,0), 4'd0});
      #1;
      got = {cur_out(), stall_cnt}; e = sb.pop_front(); checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL div_async_rst: got o=%b cnt=%0d expected o=%b cnt=%0d", got.o, got.cnt, e.o, e.cnt);
      end
      for (int i = 0; i < 4; i++) begin
         tick(1'b0);
         sb.push_back({mk(0,0,2'b00,2'b00,1,1,0,1,0,0), 4'd0});
         #2;
         got = {cur_out(), stall_cnt}; e = sb.pop_front(); checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL div_rst_hold[%0d]: got o=%b cnt=%0d expected o=%b cnt=%0d", i, got.o, got.cnt, e.o, e.cnt);
         end
      end
      clear_inputs();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick(1'b0);
         sb.push_back({mk(0,0,2'b00,2'b00,0,0,0,0,0,0), 4'd0});
         #2;
         got = {cur_out(), stall_cnt}; e = sb.pop_front(); checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL div_rst_release[%0d]: got o=%b cnt=%0d expected o=%b cnt=%0d", i, got.o, got.cnt, e.o, e.cnt);
         end
      end
      tick(1'b0);
   endtask

   task automatic test_saturate();
      do_reset();
      memtoregE = 1'b1; writeregE = 5'd8; rtD = 5'd8;
      for (int i = 0; i < 20; i++) begin
         sb.push_back({mk(0,0,2'b00,2'b00,1,1,0,1,0,0), exp_cnt});
         #2;
         got = {cur_out(), stall_cnt}; e = sb.pop_front(); checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL saturate[%0d]: got o=%b cnt=%0d expected o=%b cnt=%0d", i, got.o, got.cnt, e.o, e.cnt);
         end
         tick(1'b1);
      end
      clear_inputs();
      sb.push_back({mk(0,0,2'b00,2'b00,0,0,0,0,0,0), 4'd15});
      #2;
      got = {cur_out(), stall_cnt}; e = sb.pop_front(); checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL saturate_final: got o=%b cnt=%0d expected o=%b cnt=%0d", got.o, got.cnt, e.o, e.cnt);
      end
      tick(1'b0);
   endtask

   initial begin
      test_reset();
      test_forward_e();
      test_random_forward();
      test_lwstall();
      test_branch();
      test_div_seq(5, "div_single");
      test_div_seq(10, "div_back_to_back");
      test_div_lw_reset();
      test_saturate();
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
